// File: rtl/shared_ram_arbiter.sv
// shared_ram_arbiter
// Arbitrates one single-port shared work RAM between the M68K and the Z80.
// Each CPU access becomes one IDLE -> ACCESS -> LATCH RAM cycle. The
// requester is held off with DTACK (M68K) or WAIT (Z80) until the cycle
// completes. Simultaneous requests alternate so neither side starves.
module shared_ram_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              m68k_req,
    input  logic              m68k_rw,
    input  logic [ADDR_W-1:0] m68k_addr,
    input  logic [DATA_W-1:0] m68k_din,
    output logic [DATA_W-1:0] m68k_dout,
    output logic              m68k_dtack_n,

    input  logic              z80_req,
    input  logic              z80_rd,
    input  logic [ADDR_W-1:0] z80_addr,
    input  logic [DATA_W-1:0] z80_din,
    output logic [DATA_W-1:0] z80_dout,
    output logic              z80_wait_n,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        LATCH  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic done_m68k, done_z80;
    logic last_grant_z80;   // 1 = the Z80 owned the most recent RAM cycle
    logic grant_z80;        // owner of the RAM cycle in flight
    logic grant_write;      // RAM cycle in flight is a write
    logic pend_m68k, pend_z80;
    logic pick_z80;
    logic load_grant, latch_en;

    // A side is pending until its access completes; a held request is not re-serviced.
    assign pend_m68k = m68k_req & ~done_m68k;
    assign pend_z80  = z80_req & ~done_z80;

    // Sole requester wins; on a tie the side that did not go last wins.
    assign pick_z80 = pend_z80 & (~pend_m68k | ~last_grant_z80);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic: one RAM cycle is always three clocks long.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (pend_m68k | pend_z80) state_nxt = ACCESS;
            ACCESS:  state_nxt = LATCH;
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: strobes for loading a grant and latching read data.
    always_comb begin
        load_grant = (state == IDLE) && (pend_m68k || pend_z80);
        latch_en   = (state == LATCH);
    end

    // Grant registers: drive the RAM port; write enable lasts exactly one clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr       <= '0;
            ram_din        <= '0;
            ram_we         <= 1'b0;
            last_grant_z80 <= 1'b1;
            grant_z80      <= 1'b0;
            grant_write    <= 1'b0;
        end else if (load_grant) begin
            ram_addr       <= pick_z80 ? z80_addr : m68k_addr;
            ram_din        <= pick_z80 ? z80_din  : m68k_din;
            ram_we         <= pick_z80 ? ~z80_rd  : ~m68k_rw;
            last_grant_z80 <= pick_z80;
            grant_z80      <= pick_z80;
            grant_write    <= pick_z80 ? ~z80_rd  : ~m68k_rw;
        end else begin
            ram_we         <= 1'b0;
        end
    end

    // Read data capture into the owning side's register only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m68k_dout <= '0;
            z80_dout  <= '0;
        end else if (latch_en && !grant_write) begin
            if (grant_z80) z80_dout  <= ram_q;
            else           m68k_dout <= ram_q;
        end
    end

    // Completion flags: set at LATCH if the owner still requests, cleared once req is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_m68k <= 1'b0;
            done_z80  <= 1'b0;
        end else begin
            if (!m68k_req)                      done_m68k <= 1'b0;
            else if (latch_en && !grant_z80)    done_m68k <= 1'b1;
            if (!z80_req)                       done_z80  <= 1'b0;
            else if (latch_en && grant_z80)     done_z80  <= 1'b1;
        end
    end

    // DTACK follows the registered done flag; WAIT is combinational so it stalls immediately.
    assign m68k_dtack_n = ~done_m68k;
    assign z80_wait_n   = ~pend_z80;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Testbench for shared_ram_arbiter: directed scenarios plus randomized
// transactions checked against a memory/arbitration reference model.
module tb_shared_ram_arbiter;

    localparam int AW = 11;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          m68k_req, m68k_rw;
    logic [AW-1:0] m68k_addr;
    logic [DW-1:0] m68k_din, m68k_dout;
    logic          m68k_dtack_n;
    logic          z80_req, z80_rd;
    logic [AW-1:0] z80_addr;
    logic [DW-1:0] z80_din, z80_dout;
    logic          z80_wait_n;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_q;
    logic          ram_we;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] bram    [2**AW];
    logic [DW-1:0] ref_mem [2**AW];

    int checks = 0;
    int errors = 0;
    int we_pulses = 0;
    int we_run = 0;
    int we_run_max = 0;

    bit            last_z;       // model: 1 = Z80 was granted most recently
    logic [DW-1:0] exp_m_dout;
    logic [DW-1:0] exp_z_dout;

    always #5 clk = ~clk;

    shared_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .m68k_req(m68k_req), .m68k_rw(m68k_rw), .m68k_addr(m68k_addr),
        .m68k_din(m68k_din), .m68k_dout(m68k_dout), .m68k_dtack_n(m68k_dtack_n),
        .z80_req(z80_req), .z80_rd(z80_rd), .z80_addr(z80_addr),
        .z80_din(z80_din), .z80_dout(z80_dout), .z80_wait_n(z80_wait_n),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_q(ram_q)
    );

    // Synchronous BRAM with a bench-side preload port.
    always @(posedge clk) begin
        if (pre_we)      bram[pre_addr] <= pre_data;
        else if (ram_we) bram[ram_addr] <= ram_din;
        ram_q <= bram[ram_addr];
    end

    // Write-enable pulse monitor.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            we_pulses++;
            we_run++;
            if (we_run > we_run_max) we_run_max = we_run;
        end else begin
            we_run = 0;
        end
    end

    task automatic preload_all();
        pre_we = 1'b1;
        for (int i = 0; i < 2**AW; i++) begin
            pre_addr   = AW'(i);
            pre_data   = DW'($urandom);
            ref_mem[i] = pre_data;
            @(posedge clk); #1;
        end
        pre_we = 1'b0;
    endtask

    task automatic preload_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d; ref_mem[a] = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0; m68k_req = 1'b0; z80_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        last_z = 1'b1; exp_m_dout = '0; exp_z_dout = '0;
    endtask

    // Raise the selected requests together (called at posedge+1) and report ack latencies in clocks.
    task automatic run_pair(input bit do_m, input bit m_rw, input logic [AW-1:0] m_a, input logic [DW-1:0] m_d,
                            input bit do_z, input bit z_rd, input logic [AW-1:0] z_a, input logic [DW-1:0] z_d,
                            output int m_lat, output int z_lat, output int we_delta);
        int base;
        base = we_pulses;
        m68k_rw = m_rw; m68k_addr = m_a; m68k_din = m_d; m68k_req = do_m;
        z80_rd = z_rd; z80_addr = z_a; z80_din = z_d; z80_req = do_z;
        m_lat = 0; z_lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); @(negedge clk);
            if (do_m && m_lat == 0 && m68k_dtack_n === 1'b0) m_lat = c;
            if (do_z && z_lat == 0 && z80_wait_n === 1'b1) z_lat = c;
            if ((!do_m || m_lat != 0) && (!do_z || z_lat != 0)) break;
        end
        m68k_req = 1'b0; z80_req = 1'b0;
        @(posedge clk); #1;
        we_delta = we_pulses - base;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0; z80_req = 1'b1;
        #1;
        checks++; if (z80_wait_n !== 1'b0) begin errors++; $display("FAIL reset_wait_req got %b want 0", z80_wait_n); end
        z80_req = 1'b0;
        #1;
        checks++; if (z80_wait_n !== 1'b1) begin errors++; $display("FAIL reset_wait_idle got %b want 1", z80_wait_n); end
        checks++; if (m68k_dtack_n !== 1'b1) begin errors++; $display("FAIL reset_dtack got %b want 1", m68k_dtack_n); end
        checks++; if (m68k_dout !== 8'h00 || z80_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h/%h want 00/00", m68k_dout, z80_dout); end
        checks++; if (ram_addr !== 11'h000 || ram_din !== 8'h00 || ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram got %h/%h/%b want 000/00/0", ram_addr, ram_din, ram_we); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        last_z = 1'b1; exp_m_dout = '0; exp_z_dout = '0;
    endtask

    task automatic test_m68k_write_read();
        int base, ml, zl, wd;
        base = we_pulses;
        m68k_rw = 1'b0; m68k_addr = 11'h123; m68k_din = 8'h5A; m68k_req = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (ram_we !== 1'b1 || ram_addr !== 11'h123 || ram_din !== 8'h5A) begin errors++; $display("FAIL wr_ram_port got we=%b a=%h d=%h want 1/123/5a", ram_we, ram_addr, ram_din); end
        @(posedge clk); @(negedge clk);
        checks++; if (ram_we !== 1'b0 || m68k_dtack_n !== 1'b1) begin errors++; $display("FAIL wr_access got we=%b dtack_n=%b want 0/1", ram_we, m68k_dtack_n); end
        @(posedge clk); @(negedge clk);
        checks++; if (m68k_dtack_n !== 1'b0) begin errors++; $display("FAIL wr_ack got dtack_n=%b want 0", m68k_dtack_n); end
        m68k_req = 1'b0;
        @(posedge clk); #1;
        ref_mem[11'h123] = 8'h5A; last_z = 1'b0;
        checks++; if (we_pulses - base !== 1) begin errors++; $display("FAIL wr_we_pulses got %0d want 1", we_pulses - base); end
        checks++; if (m68k_dout !== exp_m_dout) begin errors++; $display("FAIL wr_dout_hold got %h want %h", m68k_dout, exp_m_dout); end
        run_pair(1'b1, 1'b1, 11'h123, 8'h00, 1'b0, 1'b0, '0, '0, ml, zl, wd);
        exp_m_dout = 8'h5A;
        checks++; if (ml !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", ml); end
        checks++; if (m68k_dout !== 8'h5A) begin errors++; $display("FAIL rd_dout got %h want 5a", m68k_dout); end
        checks++; if (wd !== 0) begin errors++; $display("FAIL rd_no_we got %0d want 0", wd); end
    endtask

    task automatic test_z80_read();
        int lat;
        preload_one(11'h7FF, 8'hC3);
        z80_rd = 1'b1; z80_addr = 11'h7FF; z80_din = 8'h00; z80_req = 1'b1;
        #1;
        checks++; if (z80_wait_n !== 1'b0) begin errors++; $display("FAIL z80_wait_immediate got %b want 0", z80_wait_n); end
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); @(negedge clk);
            if (z80_wait_n === 1'b1) begin lat = c; break; end
        end
        z80_req = 1'b0;
        @(posedge clk); #1;
        exp_z_dout = 8'hC3; last_z = 1'b1;
        checks++; if (lat !== 3) begin errors++; $display("FAIL z80_latency got %0d want 3", lat); end
        checks++; if (z80_dout !== 8'hC3) begin errors++; $display("FAIL z80_dout got %h want c3", z80_dout); end
        checks++; if (m68k_dout !== exp_m_dout) begin errors++; $display("FAIL z80_m68k_untouched got %h want %h", m68k_dout, exp_m_dout); end
    endtask

    task automatic test_tie();
        int ml, zl, wd;
        apply_reset();
        run_pair(1'b1, 1'b1, 11'h010, 8'h00, 1'b1, 1'b1, 11'h020, 8'h00, ml, zl, wd);
        checks++; if (ml !== 3 || zl !== 6) begin errors++; $display("FAIL tie1_order got m=%0d z=%0d want 3/6", ml, zl); end
        checks++; if (m68k_dout !== ref_mem[11'h010] || z80_dout !== ref_mem[11'h020]) begin errors++; $display("FAIL tie1_data got %h/%h want %h/%h", m68k_dout, z80_dout, ref_mem[11'h010], ref_mem[11'h020]); end
        run_pair(1'b1, 1'b0, 11'h011, 8'hA7, 1'b0, 1'b0, '0, '0, ml, zl, wd);
        ref_mem[11'h011] = 8'hA7;
        checks++; if (ml !== 3 || wd !== 1) begin errors++; $display("FAIL tie_mid_write got lat=%0d we=%0d want 3/1", ml, wd); end
        run_pair(1'b1, 1'b1, 11'h011, 8'h00, 1'b1, 1'b1, 11'h020, 8'h00, ml, zl, wd);
        checks++; if (ml !== 6 || zl !== 3) begin errors++; $display("FAIL tie2_order got m=%0d z=%0d want 6/3", ml, zl); end
        checks++; if (m68k_dout !== 8'hA7) begin errors++; $display("FAIL tie2_data got %h want a7", m68k_dout); end
        last_z = 1'b0; exp_m_dout = 8'hA7; exp_z_dout = ref_mem[11'h020];
    endtask

    task automatic test_hold();
        int base, lat, bad;
        base = we_pulses;
        m68k_rw = 1'b0; m68k_addr = 11'h2AA; m68k_din = 8'h96; m68k_req = 1'b1;
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); @(negedge clk);
            if (m68k_dtack_n === 1'b0) begin lat = c; break; end
        end
        checks++; if (lat !== 3) begin errors++; $display("FAIL hold_latency got %0d want 3", lat); end
        bad = 0;
        repeat (20) begin
            @(posedge clk); @(negedge clk);
            if (m68k_dtack_n !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_dtack got %0d high cycles want 0", bad); end
        checks++; if (we_pulses - base !== 1) begin errors++; $display("FAIL hold_one_access got %0d want 1", we_pulses - base); end
        m68k_req = 1'b0;
        #1;
        checks++; if (m68k_dtack_n !== 1'b0) begin errors++; $display("FAIL hold_dtack_before_edge got %b want 0", m68k_dtack_n); end
        @(posedge clk); #1;
        checks++; if (m68k_dtack_n !== 1'b1) begin errors++; $display("FAIL hold_release got %b want 1", m68k_dtack_n); end
        ref_mem[11'h2AA] = 8'h96; last_z = 1'b0;
    endtask

    task automatic test_abort();
        int base, lat;
        bit acked;
        base = we_pulses;
        m68k_rw = 1'b0; m68k_addr = 11'h345; m68k_din = 8'hE7; m68k_req = 1'b1;
        @(posedge clk); #1;
        m68k_req = 1'b0;
        z80_rd = 1'b1; z80_addr = 11'h345; z80_din = 8'h00; z80_req = 1'b1;
        lat = 0; acked = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); @(negedge clk);
            if (m68k_dtack_n === 1'b0) acked = 1'b1;
            if (z80_wait_n === 1'b1) begin lat = c; break; end
        end
        z80_req = 1'b0;
        @(posedge clk); #1;
        ref_mem[11'h345] = 8'hE7; exp_z_dout = 8'hE7; last_z = 1'b1;
        checks++; if (acked !== 1'b0) begin errors++; $display("FAIL abort_no_ack got ack=%b want 0", acked); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL abort_idle_timing got %0d want 5", lat); end
        checks++; if (z80_dout !== 8'hE7) begin errors++; $display("FAIL abort_committed got %h want e7", z80_dout); end
        checks++; if (we_pulses - base !== 1) begin errors++; $display("FAIL abort_we got %0d want 1", we_pulses - base); end
    endtask

    task automatic test_reset_mid();
        int ml, zl, wd;
        m68k_rw = 1'b0; m68k_addr = 11'h3C0; m68k_din = ref_mem[11'h3C0]; m68k_req = 1'b1;
        @(posedge clk); #1;
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rstmid_in_access got we=%b want 1", ram_we); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b0 || ram_addr !== 11'h000 || ram_din !== 8'h00) begin errors++; $display("FAIL rstmid_ram got %b/%h/%h want 0/000/00", ram_we, ram_addr, ram_din); end
        checks++; if (m68k_dtack_n !== 1'b1 || z80_wait_n !== 1'b1) begin errors++; $display("FAIL rstmid_handshake got %b/%b want 1/1", m68k_dtack_n, z80_wait_n); end
        checks++; if (m68k_dout !== 8'h00 || z80_dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout got %h/%h want 00/00", m68k_dout, z80_dout); end
        m68k_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        last_z = 1'b1; exp_m_dout = '0; exp_z_dout = '0;
        run_pair(1'b1, 1'b1, 11'h3C0, 8'h00, 1'b0, 1'b0, '0, '0, ml, zl, wd);
        exp_m_dout = ref_mem[11'h3C0]; last_z = 1'b0;
        checks++; if (ml !== 3 || m68k_dout !== exp_m_dout) begin errors++; $display("FAIL rstmid_after got lat=%0d d=%h want 3/%h", ml, m68k_dout, exp_m_dout); end
    endtask

    task automatic test_random();
        int ml, zl, wd, exp_ml, exp_zl, exp_wd, mode;
        bit do_m, do_z, m_rw, z_rd;
        logic [AW-1:0] m_a, z_a;
        logic [DW-1:0] m_d, z_d;
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            do_m = (mode != 1); do_z = (mode != 0);
            m_rw = 1'($urandom); z_rd = 1'($urandom);
            m_a = AW'($urandom); z_a = AW'($urandom);
            if (do_m && do_z && z_a == m_a) z_a = z_a ^ 11'h001;
            m_d = DW'($urandom); z_d = DW'($urandom);
            exp_ml = 0; exp_zl = 0; exp_wd = 0;
            if (do_m && do_z) begin
                exp_ml = last_z ? 3 : 6;
                exp_zl = last_z ? 6 : 3;
            end else if (do_m) begin
                exp_ml = 3; last_z = 1'b0;
            end else begin
                exp_zl = 3; last_z = 1'b1;
            end
            if (do_m && m_rw) exp_m_dout = ref_mem[m_a];
            if (do_z && z_rd) exp_z_dout = ref_mem[z_a];
            if (do_m && !m_rw) exp_wd++;
            if (do_z && !z_rd) exp_wd++;
            run_pair(do_m, m_rw, m_a, m_d, do_z, z_rd, z_a, z_d, ml, zl, wd);
            if (do_m && !m_rw) ref_mem[m_a] = m_d;
            if (do_z && !z_rd) ref_mem[z_a] = z_d;
            checks++; if (ml !== exp_ml || zl !== exp_zl) begin errors++; $display("FAIL rand%0d_latency got m=%0d z=%0d want %0d/%0d", it, ml, zl, exp_ml, exp_zl); end
            checks++; if (m68k_dout !== exp_m_dout || z80_dout !== exp_z_dout) begin errors++; $display("FAIL rand%0d_dout got %h/%h want %h/%h", it, m68k_dout, z80_dout, exp_m_dout, exp_z_dout); end
            checks++; if (wd !== exp_wd) begin errors++; $display("FAIL rand%0d_we got %0d want %0d", it, wd, exp_wd); end
        end
        checks++; if (we_run_max > 1) begin errors++; $display("FAIL we_width got %0d clocks want 1", we_run_max); end
    endtask

    initial begin
        reset_n = 1'b0;
        m68k_req = 1'b0; m68k_rw = 1'b1; m68k_addr = '0; m68k_din = '0;
        z80_req = 1'b0; z80_rd = 1'b1; z80_addr = '0; z80_din = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        last_z = 1'b1; exp_m_dout = '0; exp_z_dout = '0;
        @(posedge clk); #1;
        preload_all();
        test_reset();
        test_m68k_write_read();
        test_z80_read();
        test_tie();
        test_hold();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

endmodule

// File: doc/shared_ram_arbiter.md
# shared_ram_arbiter

Arbitrates the single-port 2 KB shared work RAM between the M68K and the Z80 sound/IO CPU. It sits behind the M68K shared-RAM decode at 0x180000 and the Z80 memory decode, and has one BRAM port. It turns each CPU access into one sequenced RAM cycle and holds off the requester with DTACK (M68K) or WAIT (Z80) until that cycle completes. Simultaneous requests are served alternately, so neither CPU can starve the other.

## Interface
Parameters:
- ADDR_W, 11, shared RAM byte-address width (2 KB)
- DATA_W, 8, shared RAM data width (M68K side uses the low byte lane)

Ports (single clock `clk`; reset `reset_n` is asynchronous, active-low):
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous active-low reset
- m68k_req  in  1  shared_ram_cs & !LDS_n, held for the whole bus cycle
- m68k_rw  in  1  1 = read, 0 = write
- m68k_addr  in  ADDR_W  cpu_a[11:1]
- m68k_din  in  DATA_W  cpu_dout[7:0]
- m68k_dout  out  DATA_W  read data register
- m68k_dtack_n  out  1  0 = access complete
- z80_req  in  1  Z80 shared-RAM select (MREQ_n low & decode)
- z80_rd  in  1  1 = read (RD_n low), 0 = write
- z80_addr  in  ADDR_W  Z80 address low bits
- z80_din  in  DATA_W  Z80 write data
- z80_dout  out  DATA_W  read data register
- z80_wait_n  out  1  0 = stall Z80
- ram_addr  out  ADDR_W  BRAM address (registered)
- ram_din  out  DATA_W  BRAM write data (registered)
- ram_we  out  1  BRAM write enable, one-cycle pulse
- ram_q  in  DATA_W  BRAM read data, valid one clock after address

## Operation
- Per-side pending = req & !done. done_m68k and done_z80 set when their access completes. Each clears on the first clock its req is sampled low.
- FSM states: IDLE -> ACCESS -> LATCH -> IDLE.
- IDLE:
  - If only one side is pending, grant it.
  - If both are pending, grant the side opposite last_grant.
  - On grant: register ram_addr from the granted address. Register ram_din from the granted din. Set ram_we = granted is write. Record last_grant. Go to ACCESS.
- ACCESS: the RAM performs the read or write. ram_we returns to 0 at the end of this cycle. Go to LATCH.
- LATCH:
  - Read: capture ram_q into the granted side's dout register. The other side's dout is untouched. Write: dout is not changed.
  - If the granted req is still high, set its done. If req dropped (aborted cycle), the write is still committed but done stays clear.
  - Go to IDLE.
- m68k_dtack_n = !done_m68k, registered.
- z80_wait_n = !(z80_req & !done_z80), combinational, so WAIT asserts in the same cycle the select appears.
- A request held high after done is never re-serviced. A new access requires req to fall and rise again.
- Reset values:
  - state IDLE; last_grant = Z80, so the M68K wins the first tie
  - done flags 0; m68k_dtack_n 1; m68k_dout 0; z80_dout 0
  - ram_addr 0; ram_din 0; ram_we 0
  - z80_wait_n = !z80_req
- Reset asserted mid-access: ram_we drops immediately and the FSM returns to IDLE. A write in flight may or may not commit; no ack is given.

## Timing
- Uncontended latency: req sampled high at edge E0; ram_we/ram_addr valid after E0; ram_q valid after E1; dout and ack valid after E2. dtack_n is low and wait_n is high from E2, a 3-clock service.
- Contended: the losing side starts at the edge the FSM re-enters IDLE, so its ack arrives 3 clocks after the winner's ack. Worst case is 6 clocks.
- Back-to-back same side: minimum 1 idle clock with req low, then the next access.
- Throughput: one RAM access per 3 clocks. ram_we is never high for more than 1 clock.
- dout holds its value until the next read for that side.

## Test plan
- M68K write of 0x5A to address 0x123, then a read of 0x123 -> ram_we high exactly 1 clock with ram_addr 0x123 and ram_din 0x5A. Read returns m68k_dout 0x5A with dtack_n low 3 clocks after req rises.
- Z80 read of 0x7FF preloaded with 0xC3 -> z80_wait_n low the same cycle as req, high after 3 clocks, z80_dout 0xC3. m68k_dout is unchanged.
- M68K and Z80 requests rising on the same edge, first after reset -> M68K served first (ack at +3), Z80 ack at +6. Repeating the tie -> Z80 served first.
- M68K holds req for 20 clocks after ack -> exactly one RAM access (one ram_we pulse or one address load). dtack_n stays low until req falls, then returns high next edge.
- M68K write request dropped during ACCESS -> write committed to RAM, done not set, dtack_n stays high, FSM idle 2 clocks later.
- reset_n pulsed low during ACCESS of a write -> ram_we 0 immediately, all outputs at reset values. The next request after release is serviced normally.
